// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier. One partial product per
// RUN cycle is formed by an external (WIDTH+1)-bit adder wired to the add_* ports.
module shift_add_multiplier #(
  parameter int WIDTH = 8  // only 8 is supported; the adder must be WIDTH+1 bits
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH:0]       add_a,
  output logic [WIDTH:0]       add_b,
  output logic                 add_cin,
  input  logic [WIDTH:0]       add_sum,
  input  logic                 add_cout,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // Carry-out can never be set since acc and m both fit in WIDTH bits.
  logic unused_cout;
  assign unused_cout = add_cout;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_q == RUN) begin
      add_a = {1'b0, acc_q};
      add_b = q_q[0] ? {1'b0, m_q} : '0;
    end
  end

  assign add_cin = 1'b0;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Add then shift the 2*WIDTH+1 bit {sum, Q} right by one in a single step.
        acc_d = add_sum[WIDTH:1];
        q_d   = {add_sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d   = DONE;
          product_d = {add_sum, q_q[WIDTH-1:1]};
          done_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: behavioural 9-bit adder as the parent would
// provide, directed cases from the plan plus random operands against a*b.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [8:0]  add_a;
  logic [8:0]  add_b;
  logic        add_cin;
  logic [8:0]  add_sum;
  logic        add_cout;
  logic [1:0]  dbg_state;

  logic [9:0]  add_full;
  logic [15:0] exp_q[$];
  logic [8:0]  max_sum;
  int          test_cnt;
  int          fail_cnt;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .dbg_state (dbg_state)
  );

  // Stand-in for the parent's 9-bit CLA adder.
  assign add_full = 10'(add_a) + 10'(add_b) + 10'(add_cin);
  assign add_sum  = add_full[8:0];
  assign add_cout = add_full[9];

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one operation and checks every cycle from acceptance to the idle cycle.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input bit hold, input bit poke_run, input bit poke_done);
    logic [15:0] exp_p;
    logic [15:0] part;
    int          mask;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    exp_q.push_back(16'(av) * 16'(bv));
    if (!hold) start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      // After i steps the accumulator holds a*(b mod 2^i) >> i; step i adds a iff b[i].
      mask = (1 << i) - 1;
      part = 16'(av) * 16'(bv & 8'(mask));
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("add_a", 32'(add_a), 32'(part >> i));
      check("add_b", 32'(add_b), bv[i] ? 32'(av) : 32'd0);
      check("add_cin", 32'(add_cin), 32'd0);
      check("add_cout", 32'(add_cout), 32'd0);
      if (add_sum > max_sum) max_sum = add_sum;
      if (!hold) begin
        if (poke_run && i == 3) begin
          start = 1'b1;
          a     = 8'hFF;
          b     = 8'hFF;
        end else begin
          start = 1'b0;
          a     = 8'($urandom_range(0, 255));
          b     = 8'($urandom_range(0, 255));
        end
      end
      tick();
    end
    exp_p = exp_q.pop_front();
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("product", 32'(product), 32'(exp_p));
    if (poke_done) begin
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'hFF;
    end
    tick();
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("product_hold", 32'(product), 32'(exp_p));
    if (poke_done) start = 1'b0;
  endtask

  initial begin
    test_cnt = 0;
    fail_cnt = 0;
    max_sum  = '0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    tick();
    tick();
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    rst = 1'b0;
    tick();

    run_op(8'h0D, 8'h0B, 1'b0, 1'b0, 1'b0);
    check("p_0d_0b", 32'(product), 32'h008F);

    max_sum = '0;
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("p_ff_ff", 32'(product), 32'hFE01);
    check("max_sum_le_1fe", 32'(max_sum <= 9'h1FE), 32'd1);

    run_op(8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);
    run_op(8'h37, 8'h00, 1'b0, 1'b0, 1'b0);

    // Starts during RUN and DONE must be dropped.
    run_op(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
    check("p_12_34", 32'(product), 32'h03A8);
    tick();
    check("no_second_op", 32'(busy), 32'd0);
    run_op(8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    check("p_02_03", 32'(product), 32'h0006);

    // Reset in the middle of RUN aborts without a done pulse.
    a     = 8'hC8;
    b     = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_op(8'hC8, 8'h05, 1'b0, 1'b0, 1'b0);
    check("p_c8_05", 32'(product), 32'h03E8);

    // start held high: a new operation every 10 cycles.
    for (int i = 0; i < 3; i++) run_op(8'h80, 8'h02, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    check("p_80_02", 32'(product), 32'h0100);
    tick();

    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
